// File: rtl/tia_fb_pkg.sv
// Shared types and constants for the TIA framebuffer arbiter slice.
// Framebuffer geometry is one word per pixel; scan-out walks it linearly.
package tia_fb_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

  localparam int unsigned FB_ADDR_W = 16;
  localparam int unsigned FB_DATA_W = 7;

  localparam int unsigned FB_WIDTH       = 160;
  localparam int unsigned FB_NTSC_HEIGHT = 240;
  localparam int unsigned FB_PAL_HEIGHT  = 276;
  localparam int unsigned FB_NTSC_WORDS  = FB_WIDTH * FB_NTSC_HEIGHT;
  localparam int unsigned FB_PAL_WORDS   = FB_WIDTH * FB_PAL_HEIGHT;

  function automatic int unsigned fb_words(input logic pal);
    return pal ? FB_PAL_WORDS : FB_NTSC_WORDS;
  endfunction

endpackage

// File: rtl/tia_fb_arbiter_if.sv
// Framebuffer RAM bus: arbiter drives address/write side, RAM returns
// read data one cycle after the address.
interface tia_fb_arbiter_if
  import tia_fb_pkg::*;
#(
  parameter int unsigned AW = FB_ADDR_W,
  parameter int unsigned DW = FB_DATA_W
);
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  modport master (
    output ram_addr_o,
    output ram_we_o,
    output ram_wdata_o,
    input  ram_rdata_i
  );

  modport slave (
    input  ram_addr_o,
    input  ram_we_o,
    input  ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous write-buffer FIFO. Head is visible combinationally; a push
// while full is accepted when a pop happens in the same cycle.
module fb_wr_fifo #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      level;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level == (PW+1)'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;
  assign dout_o  = mem[rd_ptr];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the level covers them.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= din_i;
  end

endmodule

// File: rtl/tia_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads win, buffered TIA writes
// fill the gaps, and a starvation limiter forces the write FIFO to drain.
module tia_fb_arbiter
  import tia_fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = FB_ADDR_W,
  parameter int unsigned DATA_WIDTH   = FB_DATA_W,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_stb_i,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic                         rd_req_i,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
  output logic                         rd_gnt_o,
  output logic                         rd_valid_o,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  tia_fb_arbiter_if.master             ram,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic [7:0]                   drop_cnt_o,
  input  logic                         clr_drop_i
);
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [EW-1:0]         fifo_dout;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;
  logic [SW-1:0]         starve_cnt;
  logic                  rd_p1;
  logic                  rd_p2;
  gnt_e                  gnt;

  fb_wr_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_stb_i),
    .din_i   ({wr_addr_i, wr_data_i}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign {head_addr, head_data} = fifo_dout;

  always_comb begin
    gnt = GNT_IDLE;
    if (!fifo_empty && (starve_cnt == SW'(STARVE_LIMIT))) gnt = GNT_WR;
    else if (rd_req_i)                                     gnt = GNT_RD;
    else if (!fifo_empty)                                  gnt = GNT_WR;
  end

  assign rd_gnt_o = (gnt == GNT_RD);
  assign pop      = (gnt == GNT_WR);
  assign drop     = wr_stb_i && fifo_full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if ((gnt == GNT_WR) || fifo_empty) begin
      starve_cnt <= '0;
    end else if ((gnt == GNT_RD) && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // RAM command register; wdata is left alone on reads and idle cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ram.ram_addr_o  <= '0;
      ram.ram_we_o    <= 1'b0;
      ram.ram_wdata_o <= '0;
    end else begin
      ram.ram_we_o <= 1'b0;
      unique case (gnt)
        GNT_RD: ram.ram_addr_o <= rd_addr_i;
        GNT_WR: begin
          ram.ram_addr_o  <= head_addr;
          ram.ram_wdata_o <= head_data;
          ram.ram_we_o    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // rd_p1: address on the bus; rd_p2: RAM data valid, captured at its end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_p1      <= rd_gnt_o;
      rd_p2      <= rd_p1;
      rd_valid_o <= rd_p2;
      if (rd_p2) rd_data_o <= ram.ram_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_o <= '0;
    end else if (clr_drop_i) begin
      drop_cnt_o <= '0;
    end else if (drop && (drop_cnt_o != 8'hFF)) begin
      drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_tia_fb_arbiter.sv
// Self-checking bench for tia_fb_arbiter: directed table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_tia_fb_arbiter;
  import tia_fb_pkg::*;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 7;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wr_stb = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          clr_drop = 1'b0;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] fifo_level;
  logic [7:0]    drop_cnt;

  int nchk = 0;
  int nerr = 0;

  tia_fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  tia_fb_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_stb_i     (wr_stb),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rd_req_i     (rd_req),
    .rd_addr_i    (rd_addr),
    .rd_gnt_o     (rd_gnt),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .ram          (bus),
    .fifo_level_o (fifo_level),
    .drop_cnt_o   (drop_cnt),
    .clr_drop_i   (clr_drop)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] ramfn(input logic [AW-1:0] a);
    if (a == 16'h0500) return 7'h11;
    return a[6:0] ^ a[13:7] ^ {5'b0, a[15:14]};
  endfunction

  // Synchronous RAM: contents are a fixed function of address.
  always @(posedge clk_i) bus.ram_rdata_i <= ramfn(bus.ram_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  wr_t           mq[$];
  rd_t           rq[$];
  int            m_cyc = 0;
  int            m_starve, m_drop;
  logic [AW-1:0] m_addr;
  logic          m_we, m_valid;
  logic [DW-1:0] m_wdata, m_rdata;

  // 0 idle, 1 read, 2 write
  function automatic int m_choice();
    if (mq.size() > 0 && m_starve == LIMIT) return 2;
    if (rd_req) return 1;
    if (mq.size() > 0) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    rq.delete();
    m_starve = 0;
    m_drop = 0;
    m_addr = '0;
    m_we = 1'b0;
    m_wdata = '0;
    m_valid = 1'b0;
    m_rdata = '0;
  endtask

  task automatic model_step();
    int  c;
    bit  had, dropped;
    wr_t h, n;
    rd_t r;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    c = m_choice();
    had = (mq.size() > 0);
    m_we = 1'b0;
    if (c == 1) begin
      m_addr = rd_addr;
      r.due = m_cyc + 3;
      r.d = ramfn(rd_addr);
      rq.push_back(r);
    end else if (c == 2) begin
      h = mq.pop_front();
      m_addr = h.a;
      m_wdata = h.d;
      m_we = 1'b1;
    end
    dropped = 1'b0;
    if (wr_stb) begin
      if (mq.size() < DEPTH) begin
        n.a = wr_addr;
        n.d = wr_data;
        mq.push_back(n);
      end else dropped = 1'b1;
    end
    if (clr_drop) m_drop = 0;
    else if (dropped && m_drop < 255) m_drop++;
    if (c == 2 || !had) m_starve = 0;
    else if (c == 1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    m_cyc++;
    m_valid = 1'b0;
    if (rq.size() > 0 && rq[0].due == m_cyc) begin
      r = rq.pop_front();
      m_valid = 1'b1;
      m_rdata = r.d;
    end
  endtask

  // ---------------- cycle driver ----------------
  logic          o_gnt, o_we, o_valid;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_rdata;
  int            o_level, o_drop;

  task automatic tick();
    @(negedge clk_i);
    o_gnt = rd_gnt; o_we = bus.ram_we_o; o_addr = bus.ram_addr_o;
    o_wdata = bus.ram_wdata_o; o_valid = rd_valid; o_rdata = rd_data;
    o_level = int'(fifo_level); o_drop = int'(drop_cnt);
    chk("m_gnt", o_gnt, m_choice() == 1);
    chk("m_we", o_we, m_we);
    chk("m_addr", o_addr, m_addr);
    chk("m_wdata", o_wdata, m_wdata);
    chk("m_valid", o_valid, m_valid);
    chk("m_rdata", o_rdata, m_rdata);
    chk("m_level", o_level, mq.size());
    chk("m_drop", o_drop, m_drop);
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_stb = 1'b0; rd_req = 1'b0; clr_drop = 1'b0;
  endtask

  typedef struct {
    logic wr; logic [AW-1:0] wa; logic [DW-1:0] wd; logic rr; logic [AW-1:0] ra;
    logic eg; logic ewe; logic [AW-1:0] ea; logic [DW-1:0] ewd;
    logic ev; logic [DW-1:0] ed; int el;
  } vec_t;
  vec_t tbl[8];

  initial begin
    // lone write then a single read; one row per cycle
    tbl[0] = '{1'b1, 16'h0123, 7'h2A, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 7'h00, 1'b0, 7'h00, 0};
    tbl[1] = '{1'b0, 16'h0000, 7'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 7'h00, 1'b0, 7'h00, 1};
    tbl[2] = '{1'b0, 16'h0000, 7'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0123, 7'h2A, 1'b0, 7'h00, 0};
    tbl[3] = '{1'b0, 16'h0000, 7'h00, 1'b1, 16'h0500, 1'b1, 1'b0, 16'h0123, 7'h2A, 1'b0, 7'h00, 0};
    tbl[4] = '{1'b0, 16'h0000, 7'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0500, 7'h2A, 1'b0, 7'h00, 0};
    tbl[5] = '{1'b0, 16'h0000, 7'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0500, 7'h2A, 1'b0, 7'h00, 0};
    tbl[6] = '{1'b0, 16'h0000, 7'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0500, 7'h2A, 1'b1, 7'h11, 0};
    tbl[7] = '{1'b0, 16'h0000, 7'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0500, 7'h2A, 1'b0, 7'h11, 0};

    model_reset();
    #1;
    chk("rst_gnt", rd_gnt, 0);
    chk("rst_we", bus.ram_we_o, 0);
    chk("rst_addr", bus.ram_addr_o, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_cnt, 0);
    repeat (3) tick();
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) begin
      wr_stb = tbl[i].wr; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_req = tbl[i].rr; rd_addr = tbl[i].ra;
      tick();
      chk("tbl_gnt", o_gnt, tbl[i].eg);
      chk("tbl_we", o_we, tbl[i].ewe);
      chk("tbl_addr", o_addr, tbl[i].ea);
      chk("tbl_wdata", o_wdata, tbl[i].ewd);
      chk("tbl_valid", o_valid, tbl[i].ev);
      chk("tbl_rdata", o_rdata, tbl[i].ed);
      chk("tbl_level", o_level, tbl[i].el);
    end
    idle_inputs();

    // starvation: reads held, one queued write is forced after LIMIT grants
    rd_req = 1'b1; rd_addr = 16'h0A00;
    wr_stb = 1'b1; wr_addr = 16'h0777; wr_data = 7'h15;
    tick();
    wr_stb = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      tick();
      chk("starve_rd", o_gnt, 1);
    end
    tick();
    chk("starve_force", o_gnt, 0);
    tick();
    chk("starve_resume", o_gnt, 1);
    chk("starve_we", o_we, 1);
    chk("starve_addr", o_addr, 16'h0777);
    chk("starve_wdata", o_wdata, 7'h15);
    idle_inputs();
    repeat (4) tick();

    // overflow under continuous reads, then push+pop while full, then clear
    rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_stb = 1'b1; wr_addr = AW'(16'h0100 + i); wr_data = DW'(i + 1);
      tick();
    end
    wr_stb = 1'b0;
    tick();
    chk("ovf_level", o_level, 4);
    chk("ovf_drop", o_drop, 2);
    repeat (2) tick();
    wr_stb = 1'b1; wr_addr = 16'h01FF; wr_data = 7'h7F;
    tick();
    chk("full_force_gnt", o_gnt, 0);
    chk("full_level_pre", o_level, 4);
    wr_stb = 1'b0; clr_drop = 1'b1;
    tick();
    chk("full_level_post", o_level, 4);
    chk("full_drop", o_drop, 2);
    chk("full_we", o_we, 1);
    chk("full_head_addr", o_addr, 16'h0100);
    clr_drop = 1'b0;
    tick();
    chk("clr_drop", o_drop, 0);
    idle_inputs();
    repeat (8) tick();
    chk("drain_level", o_level, 0);

    // reset mid-read with a write still queued
    rd_req = 1'b1; rd_addr = 16'h0500;
    wr_stb = 1'b1; wr_addr = 16'h0042; wr_data = 7'h33;
    tick();
    wr_stb = 1'b0;
    tick();
    chk("rmid_gnt", o_gnt, 1);
    rd_req = 1'b0;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rmid_we", bus.ram_we_o, 0);
    chk("rmid_addr", bus.ram_addr_o, 0);
    chk("rmid_level", fifo_level, 0);
    chk("rmid_valid", rd_valid, 0);
    repeat (2) tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rmid_no_valid", o_valid, 0);
      chk("rmid_no_we", o_we, 0);
    end

    // random traffic against the model, with occasional async resets
    for (int i = 0; i < 1500; i++) begin
      rst_ni   = ($urandom_range(0, 299) != 0);
      if (!rst_ni) model_reset();
      wr_stb   = ($urandom_range(0, 9) < 4);
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      rd_req   = ($urandom_range(0, 9) < 8);
      rd_addr  = AW'($urandom);
      clr_drop = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst_ni = 1'b1;
    idle_inputs();
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
